// File: rtl/iter_shift_unit.sv
// rtl/iter_shift_unit.sv - multi-cycle parametrised shift/rotate unit with start/busy/done handshake
//
// Shifts or rotates an operand by up to STEP bit positions per clock until the
// requested amount has been applied, then pulses done for one cycle.
//
// Ports:
//   clock   rising-edge clock
//   clear   asynchronous active-high reset
//   start   request, accepted whenever busy is low (IDLE or DONE)
//   op      0 SHL, 1 SHR, 2 SHRA, 3 ROL, 4 ROR, 5..7 illegal
//   a       operand
//   amount  shift/rotate count, 0..WIDTH-1
//   busy    high while stepping (RUN)
//   done    one-cycle pulse, result valid
//   err     set when the accepted op was illegal, cleared on the next accepted start
//   result  working/result register
module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so that STEP and WIDTH themselves are representable.
  localparam logic [AMT_W:0] STEP_W  = (AMT_W+1)'(STEP);
  localparam logic [AMT_W:0] WIDTH_W = (AMT_W+1)'(WIDTH);

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W:0]   k;
  logic [AMT_W:0]   k_inv;
  logic [AMT_W-1:0] rem_next;
  logic [WIDTH-1:0] stepped;
  logic             illegal_in;

  assign illegal_in = (op > 3'd4);

  // Step size for this cycle: never overshoot the remaining count.
  assign k        = ({1'b0, remaining} < STEP_W) ? {1'b0, remaining} : STEP_W;
  assign k_inv    = WIDTH_W - k;
  assign rem_next = remaining - k[AMT_W-1:0];

  // A right shift by WIDTH (k = 0) yields zero, so the rotate terms stay
  // correct even when k is zero.
  always_comb begin
    stepped = result;
    case (op_q)
      3'd0:    stepped = result << k;
      3'd1:    stepped = result >> k;
      3'd2:    stepped = $signed(result) >>> k;
      3'd3:    stepped = (result << k) | (result >> k_inv);
      3'd4:    stepped = (result >> k) | (result << k_inv);
      default: stepped = result;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = (amount == '0 || illegal_in) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rem_next == '0) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      result    <= '0;
      remaining <= '0;
      op_q      <= 3'd0;
      err       <= 1'b0;
    end else if (state_q != RUN) begin
      if (start) begin
        result    <= a;
        op_q      <= op;
        remaining <= amount;
        err       <= illegal_in;
      end
    end else begin
      result    <= stepped;
      remaining <= rem_next;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_iter_shift_unit.sv
// tb/tb_iter_shift_unit.sv - self-checking bench for iter_shift_unit
module tb_iter_shift_unit;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [4:0]  amount = '0;
  logic        busy, done, err;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  iter_shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clock  (clock),
    .clear  (clear),
    .start  (start),
    .op     (op),
    .a      (a),
    .amount (amount),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: whole-amount shift/rotate described bit by bit.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] av, input int am);
    logic [31:0] r;
    r = av;
    case (o)
      3'd0: for (int i = 0; i < 32; i++) r[i] = (i - am >= 0) ? av[i - am] : 1'b0;
      3'd1: for (int i = 0; i < 32; i++) r[i] = (i + am < 32) ? av[i + am] : 1'b0;
      3'd2: for (int i = 0; i < 32; i++) r[i] = (i + am < 32) ? av[i + am] : av[31];
      3'd3: for (int i = 0; i < 32; i++) r[(i + am) % 32] = av[i];
      3'd4: for (int i = 0; i < 32; i++) r[i] = av[(i + am) % 32];
      default: r = av;
    endcase
    return r;
  endfunction

  function automatic int ref_busy(input logic [2:0] o, input int am);
    if (o > 3'd4) return 0;
    return (am + STEP - 1) / STEP;
  endfunction

  // Issues one op, waits for done, checks latency, busy length, result and err.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av, input logic [4:0] am);
    int lat;
    int bc;
    @(posedge clock); #1;
    check({tag, "_done_low_before"}, {31'd0, done}, 32'd0);
    op = o; a = av; amount = am; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    bc = 0;
    while (!done && lat < 64) begin
      if (busy) bc++;
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 1 + ref_busy(o, int'(am)));
    check({tag, "_busy_cycles"}, bc, ref_busy(o, int'(am)));
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_result"}, result, ref_result(o, av, int'(am)));
    check({tag, "_err"}, {31'd0, err}, {31'd0, (o > 3'd4)});
  endtask

  initial begin
    int lat;
    int ndone;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [4:0]  ram;

    // Reset state
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;

    // Directed cases
    run_op("shl31", 3'd0, 32'h0000_0001, 5'd31);
    check("shl31_value", result, 32'h8000_0000);
    run_op("shra4", 3'd2, 32'h8000_00F0, 5'd4);
    check("shra4_value", result, 32'hF800_000F);
    run_op("shr4", 3'd1, 32'h8000_00F0, 5'd4);
    check("shr4_value", result, 32'h0800_000F);
    run_op("ror8", 3'd4, 32'h1234_5678, 5'd8);
    check("ror8_value", result, 32'h7812_3456);
    run_op("rol0", 3'd3, 32'h1234_5678, 5'd0);
    check("rol0_value", result, 32'h1234_5678);

    // start pulsed while busy is ignored
    @(posedge clock); #1;
    op = 3'd0; a = 32'h0000_0001; amount = 5'd31; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 64) begin
      if (lat == 2) begin
        op = 3'd4; a = 32'hFFFF_0000; amount = 5'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    check("ignore_latency", lat, 9);
    check("ignore_result", result, 32'h8000_0000);

    // start held through the DONE cycle: back-to-back acceptance
    @(posedge clock); #1;
    op = 3'd0; a = 32'h0000_0001; amount = 5'd4; start = 1'b1;
    @(posedge clock); #1;
    check("b2b_first_busy", {31'd0, busy}, 32'd1);
    op = 3'd3; a = 32'h8000_0001; amount = 5'd1;
    @(posedge clock); #1;
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_result", result, 32'h0000_0010);
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b_second_busy", {31'd0, busy}, 32'd1);
    @(posedge clock); #1;
    check("b2b_second_done", {31'd0, done}, 32'd1);
    check("b2b_second_result", result, 32'h0000_0003);

    // clear in the third RUN cycle abandons the op
    @(posedge clock); #1;
    op = 3'd0; a = 32'h0000_0001; amount = 5'd31; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("pre_clear_busy", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    #1;
    check("clear_busy", {31'd0, busy}, 32'd0);
    check("clear_done", {31'd0, done}, 32'd0);
    check("clear_err", {31'd0, err}, 32'd0);
    check("clear_result", result, 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(posedge clock); #1;
    end
    check("clear_no_done", ndone, 0);
    run_op("post_clear_ror8", 3'd4, 32'h1234_5678, 5'd8);
    check("post_clear_value", result, 32'h7812_3456);

    // Illegal op, then a legal op clears err
    run_op("illegal5", 3'd5, 32'hDEAD_BEEF, 5'd7);
    check("illegal_value", result, 32'hDEAD_BEEF);
    run_op("after_illegal", 3'd3, 32'h0F0F_0000, 5'd5);

    // Randomised ops against the reference
    for (int n = 0; n < 40; n++) begin
      ro  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      ram = (n % 8 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      run_op("rand", ro, ra, ram);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_shift_unit.md
# iter_shift_unit

Multi-cycle, parametrised shift/rotate unit for the datapath ALU. It generalises the combinational shift and rotate blocks to any power-of-two `WIDTH` and a configurable per-cycle step. It also adds a start/busy/done handshake and an illegal-op flag. It sits beside the ALU and is started by control when a shift-class instruction issues. Its registered result is read when `done` pulses.

## Interface
- `WIDTH`, 32: operand width. Power of two, ≥ 2.
- `STEP`, 4: maximum bit positions shifted per cycle. Legal range 1..`WIDTH`.
- `AMT_W` (localparam) = clog2(`WIDTH`): width of the shift-amount field.

Ports:
- `clock`  in  1  rising-edge clock.
- `clear`  in  1  reset; asynchronous, active-high.
- `start`  in  1  request; accepted when `busy`=0.
- `op`  in  3  0 SHL, 1 SHR (logical), 2 SHRA (arithmetic), 3 ROL, 4 ROR, 5–7 illegal.
- `a`  in  `WIDTH`  operand.
- `amount`  in  `AMT_W`  shift/rotate count, 0..`WIDTH`-1.
- `busy`  out  1  high while state is RUN.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `err`  out  1  high with `done` when the op was illegal.
- `result`  out  `WIDTH`  working/result register.

## Operation
- States: IDLE, RUN, DONE.
- Start acceptance: `start` is sampled in IDLE or DONE, i.e. whenever `busy`=0.
  - On acceptance, latch `op` and `amount` into `remaining`, and load `result` ← `a`.
  - Next state: DONE if `amount`=0 or `op` is illegal; otherwise RUN.
- Illegal op: `err` ← 1, `result` = `a` unchanged. `err` is cleared on the next accepted start.
- RUN step, once per clock edge:
  - k = min(`remaining`, `STEP`). Apply the latched op by k to `result`, then `remaining` ← `remaining` − k.
  - If the new `remaining` = 0, go to DONE; otherwise stay in RUN.
- Per-op behaviour on a step of k:
  - SHL and SHR zero-fill.
  - SHRA replicates `result[WIDTH-1]`.
  - ROL and ROR wrap bits end-around; no bits are lost.
  - The composition of steps must equal a single shift/rotate by `amount`.
- DONE lasts exactly one cycle with `done`=1. Next state is RUN/DONE on an accepted `start`, otherwise IDLE.
- `start` while `busy`=1 is ignored; latched operands are not disturbed.
- `result` holds its value in IDLE until the next accepted start.
- `clear` asynchronously forces:
  - state IDLE;
  - `result`=0, `remaining`=0, `busy`=0, `done`=0, `err`=0.
  - An operation in flight is abandoned; no `done` pulse follows.

## Timing
- Start accepted at the edge ending cycle T. `done`=1 in cycle T+1+ceil(`amount`/`STEP`).
  - `amount`=0 or illegal op: `done` in cycle T+1.
- `busy` is high for exactly ceil(`amount`/`STEP`) cycles, from T+1 onward.
- Throughput: a start presented in the DONE cycle is accepted. The next op begins with no idle gap.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Reset values: `busy`=0, `done`=0, `err`=0, `result`=0.

## Test plan
Defaults: `WIDTH`=32, `STEP`=4.
- SHL, `a`=0x0000_0001, `amount`=31 → `busy` for 8 cycles; `done` in T+9; `result`=0x8000_0000.
- SHRA, `a`=0x8000_00F0, `amount`=4 → `done` in T+2, `result`=0xF800_000F.
- SHR on the same `a` → `result`=0x0800_000F.
- ROR, `a`=0x1234_5678, `amount`=8 → `done` in T+3, `result`=0x7812_3456.
- ROL, `amount`=0 → `done` in T+1, `result`=0x1234_5678.
- Handshake:
  - `start` pulsed during `busy` → ignored, first result unchanged.
  - `start` held through the DONE cycle → second op (ROL 0x8000_0001 by 1) accepted back-to-back; `result`=0x0000_0003.
- `clear` in the 3rd RUN cycle of SHL-by-31 → all outputs 0 immediately; no `done`. The following ROR-by-8 still completes correctly.
- `op`=5, `a`=0xDEAD_BEEF → `done`=1 and `err`=1 in T+1, `result`=0xDEAD_BEEF.
- The next legal op clears `err`.
